// File: rtl/instr_fetch.sv
// Instruction fetch stage for a byte-wide synchronous ROM.
// Walks four consecutive byte addresses per instruction, absorbs the ROM's
// one-cycle read latency and assembles a little-endian 32-bit word that is
// handed to decode over a valid/ready handshake. A redirect port restarts
// fetch at a new word-aligned address.
//
// Handshake: instr/instr_pc are held stable while instr_valid=1; a transfer
// happens on a rising edge where instr_valid & instr_ready are both high, and
// instr_valid only falls after a transfer, a redirect or reset.
module instr_fetch #(
  parameter int                       ADDRESS_WIDTH = 14,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [7:0]               rom_data,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     dbg_state
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] OFF3  = ADDRESS_WIDTH'(3);
  localparam logic [ADDRESS_WIDTH-1:0] OFF4  = ADDRESS_WIDTH'(4);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN = ~ADDRESS_WIDTH'(3);

  state_t                   state, state_nxt;
  logic [2:0]               cnt, cnt_nxt;
  logic [ADDRESS_WIDTH-1:0] fetch_pc, pc_nxt;
  logic                     valid_nxt;
  logic [31:0]              instr_buf;
  logic                     cap_en;
  logic [1:0]               byte_sel;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  // Next-state and datapath control: byte walk, handshake and redirect.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pc_nxt    = fetch_pc;
    valid_nxt = instr_valid;
    cap_en    = 1'b0;
    case (state)
      FETCH: begin
        // cnt=0 sees the byte of a stale address, so it is never captured.
        if (cnt != 3'd0) cap_en = 1'b1;
        if (cnt < 3'd4) begin
          cnt_nxt = cnt + 3'd1;
        end else begin
          state_nxt = HOLD;
          valid_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (instr_valid && instr_ready) begin
          pc_nxt    = fetch_pc + OFF4;
          cnt_nxt   = 3'd0;
          state_nxt = FETCH;
          valid_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = FETCH;
        cnt_nxt   = 3'd0;
        valid_nxt = 1'b0;
      end
    endcase
    // Redirect wins over the sequential pc; a coincident handshake still
    // counts as taken because valid was high on that edge.
    if (redirect_valid) begin
      pc_nxt    = redirect_pc & ALIGN;
      cnt_nxt   = 3'd0;
      state_nxt = FETCH;
      valid_nxt = 1'b0;
      cap_en    = 1'b0;
    end
  end

  // cnt=1..4 captures bytes 0..3; the low two bits of cnt-1 pick the lane.
  assign byte_sel = cnt[1:0] - 2'd1;

  // Fetch pointer, byte counter, valid flag and instruction assembly buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      cnt         <= 3'd0;
      instr_valid <= 1'b0;
      instr_buf   <= 32'd0;
    end else begin
      fetch_pc    <= pc_nxt;
      cnt         <= cnt_nxt;
      instr_valid <= valid_nxt;
      if (cap_en) instr_buf[{byte_sel, 3'b000} +: 8] <= rom_data;
    end
  end

  // Outputs: ROM address walks pc..pc+3 and parks on pc+3 while waiting.
  always_comb begin
    rom_addr  = fetch_pc + OFF3;
    dbg_state = state;
    if (state == FETCH && cnt <= 3'd3) rom_addr = fetch_pc + ADDRESS_WIDTH'(cnt);
  end

  assign instr    = instr_buf;
  assign instr_pc = {{(32-ADDRESS_WIDTH){1'b0}}, fetch_pc};

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a table of per-cycle vectors plus
// hand-written sequences for asynchronous reset and top-of-ROM wrap.
module tb_instr_fetch;
  localparam int AW = 14;
  localparam logic [31:0] I0 = 32'h00a00513;
  localparam logic [31:0] I1 = 32'h00b00593;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, rst_n_w;
  logic [AW-1:0] rom_addr, rom_addr_w;
  logic [7:0]    rom_data, rom_data_w;
  logic [31:0]   instr, instr_w, instr_pc, instr_pc_w;
  logic          instr_valid, instr_valid_w;
  logic          instr_ready, instr_ready_w;
  logic          redirect_valid, redirect_valid_w;
  logic [AW-1:0] redirect_pc, redirect_pc_w;
  logic          dbg_state, dbg_state_w;

  logic [7:0] rom [0:(1<<AW)-1];

  // Synchronous ROM models, one read port per DUT.
  always @(posedge clk) rom_data   <= rom[rom_addr];
  always @(posedge clk) rom_data_w <= rom[rom_addr_w];

  instr_fetch #(.ADDRESS_WIDTH(AW), .RESET_PC(14'h0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .dbg_state(dbg_state)
  );

  instr_fetch #(.ADDRESS_WIDTH(AW), .RESET_PC(14'h3FFC)) u_wrap (
    .clk(clk), .rst_n(rst_n_w), .rom_addr(rom_addr_w), .rom_data(rom_data_w),
    .instr(instr_w), .instr_pc(instr_pc_w), .instr_valid(instr_valid_w),
    .instr_ready(instr_ready_w), .redirect_valid(redirect_valid_w),
    .redirect_pc(redirect_pc_w), .dbg_state(dbg_state_w)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          rst;
    bit          redir;
    logic [13:0] rpc;
    bit          rdy;
    logic [13:0] e_addr;
    bit          e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, input bit redir, input logic [13:0] rpc, input bit rdy,
                     input logic [13:0] ea, input bit ev, input logic [31:0] ei,
                     input logic [31:0] ep);
    vec_t v;
    v.rst = rst; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
    v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc = ep;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; rst_n_w = 1'b0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    instr_ready_w = 1'b1; redirect_valid_w = 1'b0; redirect_pc_w = '0;
    for (int a = 0; a < (1<<AW); a++) rom[a] = 8'h00;
    rom[0] = 8'h13; rom[1] = 8'h05; rom[2] = 8'ha0; rom[3] = 8'h00;
    rom[4] = 8'h93; rom[5] = 8'h05; rom[6] = 8'hb0; rom[7] = 8'h00;
    rom[14'h3FFC] = 8'h6f; rom[14'h3FFD] = 8'h00;
    rom[14'h3FFE] = 8'h00; rom[14'h3FFF] = 8'h00;

    // Straight-line fetch with decode always ready.
    add(1, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) add(0, 0, 0, 1, 14'(k), 0, 0, 0);
    add(0, 0, 0, 1, 3, 0, 0, 0);
    add(0, 0, 0, 1, 3, 1, I0, 0);
    for (int k = 4; k <= 7; k++) add(0, 0, 0, 1, 14'(k), 0, 0, 4);
    add(0, 0, 0, 1, 7, 0, 0, 4);
    add(0, 0, 0, 1, 7, 1, I1, 4);
    add(0, 0, 0, 1, 8, 0, 0, 8);

    // Decode stalls for 10 cycles, then accepts once.
    add(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) add(0, 0, 0, 0, 14'(k), 0, 0, 0);
    add(0, 0, 0, 0, 3, 0, 0, 0);
    for (int k = 0; k < 10; k++) add(0, 0, 0, 0, 3, 1, I0, 0);
    add(0, 0, 0, 1, 3, 1, I0, 0);
    add(0, 0, 0, 0, 4, 0, 0, 4);
    add(0, 0, 0, 0, 5, 0, 0, 4);

    // Redirect to 0x006 while cnt=2, then redirect+accept together in HOLD.
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 1, 14'h006, 0, 2, 0, 0, 0);
    for (int k = 4; k <= 7; k++) add(0, 0, 0, 0, 14'(k), 0, 0, 4);
    add(0, 0, 0, 0, 7, 0, 0, 4);
    add(0, 0, 0, 0, 7, 1, I1, 4);
    add(0, 1, 14'h000, 1, 7, 1, I1, 4);
    for (int k = 0; k <= 3; k++) add(0, 0, 0, 0, 14'(k), 0, 0, 0);
    add(0, 0, 0, 0, 3, 0, 0, 0);
    add(0, 0, 0, 0, 3, 1, I0, 0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      if (v.rst) do_reset();
      redirect_valid = v.redir;
      redirect_pc    = v.rpc;
      instr_ready    = v.rdy;
      chk($sformatf("v%0d_addr", i), 32'(rom_addr), 32'(v.e_addr));
      chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(v.e_valid));
      chk($sformatf("v%0d_pc", i), instr_pc, v.e_pc);
      if (v.e_valid || v.rst) chk($sformatf("v%0d_instr", i), instr, v.e_instr);
      @(negedge clk);
    end
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;

    // Asynchronous reset while cnt=3 with two bytes already captured.
    do_reset();
    repeat (3) @(negedge clk);
    chk("mid_fetch_addr", 32'(rom_addr), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_fetch_valid", 32'(instr_valid), 32'd0);
    chk("arst_fetch_instr", instr, 32'd0);
    chk("arst_fetch_addr", 32'(rom_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      chk($sformatf("rf%0d_valid", k), 32'(instr_valid), (k == 5) ? 32'd1 : 32'd0);
      chk($sformatf("rf%0d_addr", k), 32'(rom_addr), (k <= 3) ? 32'(k) : 32'd3);
      if (k == 5) chk("rf5_instr", instr, I0);
      if (k < 5) @(negedge clk);
    end

    // Asynchronous reset while a valid instruction is held.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hold_valid", 32'(instr_valid), 32'd0);
    chk("arst_hold_instr", instr, 32'd0);
    chk("arst_hold_pc", instr_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Top-of-ROM wrap on the second instance.
    rst_n_w = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      logic [31:0] ea;
      ea = (k <= 3) ? 32'h3FFC + 32'(k) : ((k < 6) ? 32'h3FFF : 32'h0);
      chk($sformatf("wrap%0d_addr", k), 32'(rom_addr_w), ea);
      chk($sformatf("wrap%0d_valid", k), 32'(instr_valid_w), (k == 5) ? 32'd1 : 32'd0);
      if (k == 0) chk("wrap0_instr", instr_w, 32'd0);
      if (k == 5) begin
        chk("wrap5_instr", instr_w, 32'h0000006f);
        chk("wrap5_pc", instr_pc_w, 32'h00003FFC);
      end
      if (k == 6) chk("wrap6_pc", instr_pc_w, 32'd0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
